// File: rtl/egress_pkt_queue.sv
// Per-destination egress packet queue: synchronous FIFO with a registered output
// stage, store-and-forward release, packet/occupancy/drop accounting.
module egress_pkt_queue #(
  parameter int unsigned EGRESS_QUEUE_WIDTH = 288,
  parameter int unsigned DEPTH              = 64,
  parameter int unsigned PTR_WIDTH          = 6,
  parameter int unsigned PROG_FULL_THRESH   = 56,
  parameter bit          STORE_FWD          = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_wr_en,
  input  logic [EGRESS_QUEUE_WIDTH-1:0] iv_wr_data,
  output logic                          o_prog_full,
  output logic                          o_rd_valid,
  output logic [EGRESS_QUEUE_WIDTH-1:0] ov_rd_data,
  input  logic                          i_rd_ready,
  output logic [PTR_WIDTH:0]            ov_used,
  output logic [PTR_WIDTH:0]            ov_pkt_cnt,
  output logic [15:0]                   ov_drop_cnt,
  output logic                          o_overflow
);

  localparam int unsigned CNT_W   = PTR_WIDTH + 1;
  localparam int unsigned DROP_W  = 16;
  localparam int unsigned EOP_BIT = EGRESS_QUEUE_WIDTH - 2;

  typedef enum logic {
    REL_NORMAL,
    REL_FORCED
  } rel_state_e;

  logic [EGRESS_QUEUE_WIDTH-1:0] r_mem [DEPTH];

  logic [PTR_WIDTH-1:0]          r_wr_ptr;
  logic [PTR_WIDTH-1:0]          r_rd_ptr;
  logic [CNT_W-1:0]              r_used;
  logic [CNT_W-1:0]              r_pkt_cnt;
  logic [DROP_W-1:0]             r_drop_cnt;
  logic                          r_overflow;
  logic                          r_prog_full;
  logic                          r_rd_valid;
  logic [EGRESS_QUEUE_WIDTH-1:0] r_rd_data;
  rel_state_e                    r_state;
  rel_state_e                    w_state_nxt;

  logic             w_full;
  logic             w_wr_acc;
  logic             w_wr_drop;
  logic             w_wr_eop;
  logic             w_rd_hs;
  logic             w_rd_eop;
  logic             w_out_eop;
  logic [CNT_W-1:0] w_ram_cnt;
  logic [CNT_W-1:0] w_ram_pkts;
  logic             w_ram_empty;
  logic             w_forced_open;
  logic             w_release;
  logic             w_load;
  logic [CNT_W-1:0] w_used_nxt;
  logic [CNT_W-1:0] w_pkt_nxt;

  // Full is judged on the pre-cycle count, so a same-cycle read never rescues a write.
  assign w_full    = (r_used == CNT_W'(DEPTH));
  assign w_wr_acc  = i_wr_en & ~w_full;
  assign w_wr_drop = i_wr_en & w_full;
  assign w_wr_eop  = iv_wr_data[EOP_BIT];

  assign w_rd_hs   = r_rd_valid & i_rd_ready;
  assign w_rd_eop  = r_rd_data[EOP_BIT];
  assign w_out_eop = r_rd_valid & w_rd_eop;

  // Entries and complete packets still in RAM, excluding the output register.
  assign w_ram_cnt   = r_used - CNT_W'(r_rd_valid);
  assign w_ram_pkts  = r_pkt_cnt - CNT_W'(w_out_eop);
  assign w_ram_empty = (w_ram_cnt == '0);

  // Forced drain of an oversize packet stops once its end word sits in the output register.
  assign w_forced_open = (r_state == REL_FORCED) & ~w_out_eop;
  assign w_release     = !STORE_FWD || (w_ram_pkts != '0) || w_forced_open;
  assign w_load        = w_release & ~w_ram_empty & (~r_rd_valid | w_rd_hs);

  assign w_used_nxt = r_used + CNT_W'(w_wr_acc) - CNT_W'(w_rd_hs);
  assign w_pkt_nxt  = r_pkt_cnt + CNT_W'(w_wr_acc & w_wr_eop) - CNT_W'(w_rd_hs & w_rd_eop);

  // Release-mode state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= REL_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Enter forced release when full with no complete packet; leave when its end word is read.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      REL_NORMAL: begin
        if (STORE_FWD && w_full && (r_pkt_cnt == '0)) begin
          w_state_nxt = REL_FORCED;
        end
      end
      REL_FORCED: begin
        if (w_rd_hs && w_rd_eop) begin
          w_state_nxt = REL_NORMAL;
        end
      end
      default: w_state_nxt = REL_NORMAL;
    endcase
  end

  // Storage array; no reset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= iv_wr_data;
    end
  end

  // Pointers, counters and status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_used      <= '0;
      r_pkt_cnt   <= '0;
      r_drop_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_prog_full <= 1'b0;
    end else begin
      r_used      <= w_used_nxt;
      r_pkt_cnt   <= w_pkt_nxt;
      r_prog_full <= (r_used >= CNT_W'(PROG_FULL_THRESH));
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      end
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != {DROP_W{1'b1}}) begin
          r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
      end
    end
  end

  // Output register: registered RAM read, held stable until the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (w_load) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= r_mem[r_rd_ptr];
      end else if (w_rd_hs) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign o_prog_full = r_prog_full;
  assign o_rd_valid  = r_rd_valid;
  assign ov_rd_data  = r_rd_data;
  assign ov_used     = r_used;
  assign ov_pkt_cnt  = r_pkt_cnt;
  assign ov_drop_cnt = r_drop_cnt;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_egress_pkt_queue.sv
// Self-checking bench for egress_pkt_queue: directed scenarios plus random traffic,
// checked against a queue-based model of stored entries, packets and drops.
module tb_egress_pkt_queue;

  localparam int unsigned W     = 288;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned PW    = 6;
  localparam int unsigned THR   = 56;
  localparam int unsigned EOP   = W - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_wr_en;
  logic [W-1:0]  iv_wr_data;
  logic          o_prog_full;
  logic          o_rd_valid;
  logic [W-1:0]  ov_rd_data;
  logic          i_rd_ready;
  logic [PW:0]   ov_used;
  logic [PW:0]   ov_pkt_cnt;
  logic [15:0]   ov_drop_cnt;
  logic          o_overflow;

  egress_pkt_queue #(
    .EGRESS_QUEUE_WIDTH(W),
    .DEPTH(DEPTH),
    .PTR_WIDTH(PW),
    .PROG_FULL_THRESH(THR),
    .STORE_FWD(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_wr_en(i_wr_en),
    .iv_wr_data(iv_wr_data),
    .o_prog_full(o_prog_full),
    .o_rd_valid(o_rd_valid),
    .ov_rd_data(ov_rd_data),
    .i_rd_ready(i_rd_ready),
    .ov_used(ov_used),
    .ov_pkt_cnt(ov_pkt_cnt),
    .ov_drop_cnt(ov_drop_cnt),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] mq[$];
  int           m_drops;
  bit           m_ovf;
  bit           m_force;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_ends();
    int n = 0;
    foreach (mq[i]) if (mq[i][EOP]) n++;
    return n;
  endfunction

  function automatic logic [W-1:0] payload(input bit sop, input bit eop);
    logic [W-1:0] d;
    for (int i = 0; i < 9; i++) d[i*32 +: 32] = $urandom;
    d[W-1] = sop;
    d[W-2] = eop;
    return d;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
    m_force = 1'b0;
  endtask

  // One clock: checks the pre-edge handshake, advances the model, checks status after the edge.
  task automatic tick();
    bit           hs;
    bit           wr;
    bit           pre_full;
    int           pre_size;
    logic [W-1:0] wd;
    hs       = o_rd_valid && i_rd_ready;
    wr       = i_wr_en;
    wd       = iv_wr_data;
    pre_size = mq.size();
    pre_full = (pre_size == DEPTH);
    if (o_rd_valid) check("sf_release", W'(model_ends() > 0 || m_force), W'(1));
    if (hs) begin
      check("rd_nonempty", W'(mq.size() != 0), W'(1));
      if (mq.size() != 0) check("rd_data", ov_rd_data, mq[0]);
    end
    if (pre_full && model_ends() == 0) m_force = 1'b1;
    @(posedge clk);
    #1;
    if (hs && mq.size() != 0) begin
      if (mq[0][EOP]) m_force = 1'b0;
      void'(mq.pop_front());
    end
    if (wr) begin
      if (pre_full) begin
        if (m_drops < 65535) m_drops++;
        m_ovf = 1'b1;
      end else begin
        mq.push_back(wd);
      end
    end
    check("used", W'(ov_used), W'(mq.size()));
    check("pkt_cnt", W'(ov_pkt_cnt), W'(model_ends()));
    check("drop_cnt", W'(ov_drop_cnt), W'(m_drops));
    check("overflow", W'(o_overflow), W'(m_ovf));
    check("prog_full", W'(o_prog_full), W'(pre_size >= THR));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, W'(o_rd_valid), W'(0));
    check({tag, "_data"}, ov_rd_data, W'(0));
    check({tag, "_pf"}, W'(o_prog_full), W'(0));
    check({tag, "_used"}, W'(ov_used), W'(0));
    check({tag, "_pkt"}, W'(ov_pkt_cnt), W'(0));
    check({tag, "_drop"}, W'(ov_drop_cnt), W'(0));
    check({tag, "_ovf"}, W'(o_overflow), W'(0));
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    i_wr_en    = 1'b0;
    i_rd_ready = 1'b0;
    iv_wr_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst = 1'b1;
  endtask

  task automatic drain(input string tag);
    i_rd_ready = 1'b1;
    for (int k = 0; k < 200 && mq.size() != 0; k++) tick();
    i_rd_ready = 1'b0;
    check({tag, "_drained"}, W'(ov_used), W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] first;
    do_reset();

    // Single start+end entry: visible two cycles after the write.
    d = {36{8'hA5}};
    d[W-1] = 1'b1;
    d[W-2] = 1'b1;
    i_wr_en = 1'b1; iv_wr_data = d;
    tick();
    i_wr_en = 1'b0;
    check("t1_valid_n1", W'(o_rd_valid), W'(0));
    tick();
    check("t1_valid_n2", W'(o_rd_valid), W'(1));
    check("t1_data", ov_rd_data, d);
    i_rd_ready = 1'b1;
    tick();
    i_rd_ready = 1'b0;
    check("t1_valid_after", W'(o_rd_valid), W'(0));

    // Four-word packet held back until its end word is stored.
    for (int k = 0; k < 4; k++) begin
      i_wr_en = 1'b1; iv_wr_data = payload(k == 0, k == 3);
      tick();
      check("t2_hold", W'(o_rd_valid), W'(0));
    end
    i_wr_en = 1'b0;
    tick();
    check("t2_valid_n2", W'(o_rd_valid), W'(1));
    i_rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t2_b2b", W'(o_rd_valid), W'(1));
      tick();
    end
    i_rd_ready = 1'b0;
    check("t2_empty", W'(o_rd_valid), W'(0));

    // Programmable-full threshold.
    i_wr_en = 1'b1;
    for (int k = 0; k < 56; k++) begin
      iv_wr_data = payload(1'b1, 1'b1);
      tick();
    end
    i_wr_en = 1'b0;
    check("t3_used56", W'(ov_used), W'(56));
    check("t3_pf_lag", W'(o_prog_full), W'(0));
    tick();
    check("t3_pf_on", W'(o_prog_full), W'(1));
    i_rd_ready = 1'b1;
    tick();
    i_rd_ready = 1'b0;
    check("t3_pf_hold", W'(o_prog_full), W'(1));
    tick();
    check("t3_pf_off", W'(o_prog_full), W'(0));
    drain("t3");

    // Overflow with an oversize packet, then forced drain.
    do_reset();
    i_wr_en = 1'b1;
    for (int k = 0; k < 70; k++) begin
      iv_wr_data = payload(1'b1, 1'b0);
      if (k == 0) first = iv_wr_data;
      tick();
    end
    i_wr_en = 1'b0;
    check("t4_used", W'(ov_used), W'(64));
    check("t4_drops", W'(ov_drop_cnt), W'(6));
    check("t4_ovf", W'(o_overflow), W'(1));
    for (int k = 0; k < 10 && !o_rd_valid; k++) tick();
    check("t4_forced", W'(o_rd_valid), W'(1));
    check("t4_first", ov_rd_data, first);
    drain("t4");

    // Steady simultaneous read/write at occupancy 10 across pointer wrap.
    do_reset();
    i_wr_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      iv_wr_data = payload(1'b1, 1'b1);
      tick();
    end
    i_wr_en = 1'b0;
    tick();
    check("t5_ready", W'(o_rd_valid), W'(1));
    i_wr_en = 1'b1; i_rd_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      iv_wr_data = payload(1'b1, 1'b1);
      check("t5_b2b", W'(o_rd_valid), W'(1));
      tick();
      check("t5_used10", W'(ov_used), W'(10));
    end
    i_wr_en = 1'b0; i_rd_ready = 1'b0;
    drain("t5");

    // Asynchronous reset in the middle of a packet.
    do_reset();
    i_wr_en = 1'b1;
    iv_wr_data = payload(1'b1, 1'b1); tick();
    iv_wr_data = payload(1'b1, 1'b0); tick();
    iv_wr_data = payload(1'b0, 1'b0); tick();
    i_wr_en = 1'b0;
    check("t6_valid_pre", W'(o_rd_valid), W'(1));
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("t6_async");
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    d = payload(1'b1, 1'b1);
    i_wr_en = 1'b1; iv_wr_data = d;
    tick();
    i_wr_en = 1'b0;
    check("t6_valid_n1", W'(o_rd_valid), W'(0));
    tick();
    check("t6_valid_n2", W'(o_rd_valid), W'(1));
    check("t6_data", ov_rd_data, d);
    drain("t6");

    // Random traffic against the model, then a bounded drain of complete packets.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      i_wr_en    = ($urandom % 10) < 4;
      iv_wr_data = payload(($urandom % 4) == 0, ($urandom % 3) == 0);
      i_rd_ready = ($urandom % 10) < 7;
      tick();
    end
    i_wr_en = 1'b0; i_rd_ready = 1'b1;
    repeat (200) tick();
    check("rnd_pkts_drained", W'(ov_pkt_cnt), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
